rgb_channel_sequencer: RTL



---
 rtl/rgb_channel_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rgb_channel_sequencer.sv
// rgb_channel_sequencer
//   Upstream feeder for the 3-input channel mux. Accepts one RGB pixel per
//   valid/ready handshake into a 2-deep buffer (ACTIVE + PEND). It presents
//   the ACTIVE pixel's bytes on mux_a/b/c and steps mux_sel through the three
//   channels, one channel per accepted output beat.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  pixel handshake; in_r/g/b pixel bytes, in_last end of frame
//   mux_a/b/c       ACTIVE pixel R/G/B (0 when ACTIVE is empty)
//   mux_sel         channel select (2'b11 when idle, so the mux outputs 0)
//   out_valid/ready channel-beat handshake
//   out_ch_first    first channel beat of a pixel
//   out_ch_last     final channel beat of a pixel
//   out_frame_last  final channel beat of the in_last pixel
//   busy            a pixel is active or pending
//
// Build option
//   SEQ_BGR_ORDER_EN  when defined, channels are issued B, G, R instead of R, G, B.
//                     Timing and handshake are the same in both builds.

module rgb_channel_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic [DATA_W-1:0] mux_a,
  output logic [DATA_W-1:0] mux_b,
  output logic [DATA_W-1:0] mux_c,
  output logic [1:0]        mux_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_ch_first,
  output logic              out_ch_last,
  output logic              out_frame_last,
  output logic              busy
);

`ifdef SEQ_BGR_ORDER_EN
  localparam logic [1:0] SEL_CH0 = 2'b10;
  localparam logic [1:0] SEL_CH2 = 2'b00;
`else
  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH2 = 2'b10;
`endif
  localparam logic [1:0] SEL_CH1  = 2'b01;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, CH0 = 2'd1, CH1 = 2'd2, CH2 = 2'd3} state_t;

  state_t state, state_nxt;

  // Stage p0: PEND slot (next pixel)
  logic              vld_p0;
  logic [DATA_W-1:0] r_p0, g_p0, b_p0;
  logic              last_p0;

  // Stage p1: ACTIVE slot (pixel being serialised)
  logic              vld_p1;
  logic [DATA_W-1:0] r_p1, g_p1, b_p1;
  logic              last_p1;

  logic fire_in, beat, release_act;
  logic act_from_pend, act_from_in, pend_from_in;

  // Input can only be taken while PEND is free, so an input handshake never
  // coincides with a PEND->ACTIVE move that leaves PEND still occupied.
  assign in_ready    = !vld_p0;
  assign fire_in     = in_valid && in_ready;
  assign beat        = out_valid && out_ready;
  assign release_act = beat && (state == CH2);

  assign act_from_pend = release_act && vld_p0;
  assign act_from_in   = fire_in && (!vld_p1 || release_act);
  assign pend_from_in  = fire_in && vld_p1 && !release_act;

  // Control: slot occupancy and FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (release_act) begin
        if (vld_p0) begin
          vld_p1 <= 1'b1;
          vld_p0 <= 1'b0;
        end else begin
          vld_p1 <= fire_in;
        end
      end else if (pend_from_in) begin
        vld_p0 <= 1'b1;
      end else if (act_from_in) begin
        vld_p1 <= 1'b1;
      end
    end
  end

  // Data: slot contents are qualified by vld_p0/vld_p1, so they need no reset
  always_ff @(posedge clk) begin
    if (pend_from_in) begin
      r_p0    <= in_r;
      g_p0    <= in_g;
      b_p0    <= in_b;
      last_p0 <= in_last;
    end
    if (act_from_pend) begin
      r_p1    <= r_p0;
      g_p1    <= g_p0;
      b_p1    <= b_p0;
      last_p1 <= last_p0;
    end else if (act_from_in) begin
      r_p1    <= in_r;
      g_p1    <= in_g;
      b_p1    <= in_b;
      last_p1 <= in_last;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fire_in) state_nxt = CH0;
      CH0:  if (beat)    state_nxt = CH1;
      CH1:  if (beat)    state_nxt = CH2;
      CH2:  if (beat)    state_nxt = (vld_p0 || fire_in) ? CH0 : IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid      = 1'b0;
    mux_sel        = SEL_IDLE;
    out_ch_first   = 1'b0;
    out_ch_last    = 1'b0;
    out_frame_last = 1'b0;
    case (state)
      CH0: begin
        out_valid    = 1'b1;
        mux_sel      = SEL_CH0;
        out_ch_first = 1'b1;
      end
      CH1: begin
        out_valid = 1'b1;
        mux_sel   = SEL_CH1;
      end
      CH2: begin
        out_valid      = 1'b1;
        mux_sel        = SEL_CH2;
        out_ch_last    = 1'b1;
        out_frame_last = last_p1;
      end
      default: ;
    endcase
  end

  assign mux_a = vld_p1 ? r_p1 : '0;
  assign mux_b = vld_p1 ? g_p1 : '0;
  assign mux_c = vld_p1 ? b_p1 : '0;
  assign busy  = vld_p1 || vld_p0;

endmodule
